// File: rtl/cav14_pkg.sv
// Shared types, default geometry and pointer arithmetic for the cav14 pointer-chase pair.
package cav14_pkg;

  localparam int unsigned W_DEF = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    ERR  = 2'd2
  } state_t;

  // Wrapped writer-minus-reader distance, masked to pw bits.
  function automatic logic [31:0] occ_f(input logic [31:0] wr,
                                        input logic [31:0] rd,
                                        input int unsigned pw);
    logic [31:0] mask;
    mask  = (32'(1) << pw) - 32'(1);
    occ_f = (wr - rd) & mask;
  endfunction

endpackage

// File: rtl/cav14_ptr_occ.sv
// Occupancy between writer and reader pointers, plus the overrun flag (occupancy beyond ring depth).
module cav14_ptr_occ
  import cav14_pkg::*;
#(
  parameter int unsigned PW = W_DEF + 1
) (
  input  logic [PW-1:0] wr_ptr_i,
  input  logic [PW-1:0] rd_ptr_i,
  output logic [PW-1:0] occ_c_o,
  output logic          overrun_c_o
);

  localparam int unsigned DEPTH = 2 ** (PW - 1);

  always_comb begin
    occ_c_o     = PW'(occ_f(32'(wr_ptr_i), 32'(rd_ptr_i), PW));
    overrun_c_o = (32'(occ_c_o) > DEPTH);
  end

endmodule

// File: rtl/cav14_chase_reader.sv
// Reader end of the cav14 pointer-chase pair; prop drops (sticky) if the writer ever overtakes the reader.
// Optional CHASE_ASSERT_EN compiles in the safety assertions and the writer-step assumption.
module cav14_chase_reader
  import cav14_pkg::*;
#(
  parameter  int unsigned W  = W_DEF,
  localparam int unsigned PW = W + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [PW-1:0] wr_ptr,
  input  logic          rd_ready,
  output logic          rd_valid,
  output logic [PW-1:0] rd_ptr,
  output logic [PW-1:0] rd_count,
  output logic          prop
);

  state_t        state_q;
  logic [PW-1:0] rd_ptr_q;
  logic [PW-1:0] rd_ptr_d;
  logic          rd_valid_q;
  logic          prop_q;

  logic [PW-1:0] occ;
  logic          overrun;
  logic          fire;
  logic [PW-1:0] next_occ;

  cav14_ptr_occ #(
    .PW(PW)
  ) u_occ (
    .wr_ptr_i   (wr_ptr),
    .rd_ptr_i   (rd_ptr_q),
    .occ_c_o    (occ),
    .overrun_c_o(overrun)
  );

  // Occupancy as it will be after this cycle's handshake.
  always_comb begin
    fire     = rd_valid_q & rd_ready;
    rd_ptr_d = rd_ptr_q + PW'(1);
    next_occ = occ - PW'(fire);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      rd_ptr_q   <= '0;
      rd_valid_q <= 1'b0;
      prop_q     <= 1'b1;
    end else begin
      case (state_q)
        IDLE, READ: begin
          if (overrun) begin
            state_q    <= ERR;
            rd_valid_q <= 1'b0;
            prop_q     <= 1'b0;
          end else begin
            if (fire) rd_ptr_q <= rd_ptr_d;
            state_q    <= (next_occ != '0) ? READ : IDLE;
            rd_valid_q <= (next_occ != '0);
          end
        end
        default: begin
          // Sticky until reset, regardless of later writer movement.
          state_q    <= ERR;
          rd_valid_q <= 1'b0;
          prop_q     <= 1'b0;
        end
      endcase
    end
  end

  assign rd_valid = rd_valid_q;
  assign rd_ptr   = rd_ptr_q;
  assign rd_count = occ;
  assign prop     = prop_q;

`ifdef CHASE_ASSERT_EN
  a_prop : assert property (@(posedge clk) disable iff (rst) prop);
  a_read_nonempty : assert property (@(posedge clk) disable iff (rst)
    !(state_q == READ) || (occ != '0));
  m_writer_step : assume property (@(posedge clk) disable iff (rst)
    (PW'(wr_ptr - $past(wr_ptr)) == PW'(0)) || (PW'(wr_ptr - $past(wr_ptr)) == PW'(1)));
`else
`endif

endmodule

// File: tb/tb_cav14_chase_reader.sv
// Self-checking bench for cav14_chase_reader (W=3): directed scenarios plus randomized writer/reader traffic.
module tb_cav14_chase_reader;

  localparam int unsigned W     = 3;
  localparam int unsigned PW    = W + 1;
  localparam int unsigned DEPTH = 8;
  localparam int unsigned MOD   = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [PW-1:0] wr_ptr = '0;
  logic          rd_ready = 1'b0;
  logic          rd_valid;
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] rd_count;
  logic          prop;

  int passed = 0;
  int total  = 0;
  bit chk_en = 1'b0;

  // Reference: reader position, whether an entry is shown, and whether an overrun ever happened.
  int m_rd    = 0;
  bit m_valid = 1'b0;
  bit m_err   = 1'b0;

  cav14_chase_reader #(.W(W)) dut (
    .clk     (clk),
    .rst     (rst),
    .wr_ptr  (wr_ptr),
    .rd_ready(rd_ready),
    .rd_valid(rd_valid),
    .rd_ptr  (rd_ptr),
    .rd_count(rd_count),
    .prop    (prop)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  // Reference update on every active edge from the inputs that were presented.
  always @(posedge clk) begin
    int occ;
    int left;
    bit took;
    if (rst) begin
      m_rd = 0; m_valid = 1'b0; m_err = 1'b0;
    end else if (!m_err) begin
      occ = (int'(wr_ptr) - m_rd + MOD) % MOD;
      if (occ > DEPTH) begin
        m_err = 1'b1; m_valid = 1'b0;
      end else begin
        took = m_valid && rd_ready;
        if (took) m_rd = (m_rd + 1) % MOD;
        left = (occ - int'(took) + MOD) % MOD;
        m_valid = (left != 0);
      end
    end
  end

  // Cycle-by-cycle comparison against the reference.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("rd_valid", int'(rd_valid), int'(m_valid));
      chk("rd_ptr", int'(rd_ptr), m_rd);
      chk("rd_count", int'(rd_count), (int'(wr_ptr) - m_rd + MOD) % MOD);
      chk("prop", int'(prop), int'(!m_err));
    end
  end

  task automatic cyc(input bit r, input int w, input bit rdy);
    rst = r; wr_ptr = PW'(w); rd_ready = rdy;
    @(negedge clk);
    #1;
  endtask

  initial begin
    int w;
    int wraps;
    int maxcnt;
    int prev;
    chk_en = 1'b1;

    // Reset held with a non-empty writer
    cyc(1, 5, 0); cyc(1, 5, 0);
    chk("t1_rst_ptr", int'(rd_ptr), 0);
    chk("t1_rst_valid", int'(rd_valid), 0);
    chk("t1_rst_prop", int'(prop), 1);
    cyc(0, 5, 0);
    chk("t1_valid", int'(rd_valid), 1);
    chk("t1_count", int'(rd_count), 5);

    // Single entry, read immediately
    cyc(1, 0, 0); cyc(1, 0, 0);
    cyc(0, 0, 1);
    cyc(0, 1, 1);
    chk("t2_valid_t1", int'(rd_valid), 1);
    cyc(0, 1, 1);
    chk("t2_ptr_t2", int'(rd_ptr), 1);
    chk("t2_valid_t2", int'(rd_valid), 0);
    chk("t2_count_t2", int'(rd_count), 0);

    // Full ring, downstream stalled
    cyc(1, 0, 0);
    for (int i = 0; i < 6; i++) cyc(0, 8, 0);
    chk("t3_valid", int'(rd_valid), 1);
    chk("t3_ptr", int'(rd_ptr), 0);
    chk("t3_count", int'(rd_count), 8);
    chk("t3_prop", int'(prop), 1);

    // Writer streams, reader keeps up; pointer wraps twice
    cyc(1, 0, 0);
    w = 0; wraps = 0; maxcnt = 0; prev = 0;
    for (int i = 0; i < 40; i++) begin
      w = (w + 1) % MOD;
      cyc(0, w, 1);
      if (prev == 15 && int'(rd_ptr) == 0) wraps++;
      if (int'(rd_count) > maxcnt) maxcnt = int'(rd_count);
      prev = int'(rd_ptr);
    end
    chk("t4_wraps", wraps, 2);
    chk("t4_maxcount", maxcnt, 1);
    chk("t4_prop", int'(prop), 1);

    // Overrun is sticky until reset
    cyc(1, 0, 0);
    cyc(0, 9, 0);
    chk("t5_err_valid", int'(rd_valid), 0);
    chk("t5_err_prop", int'(prop), 0);
    cyc(0, 0, 0); cyc(0, 0, 1);
    chk("t5_sticky_prop", int'(prop), 0);
    cyc(1, 0, 0);
    chk("t5_cleared_prop", int'(prop), 1);

    // Reset in the middle of a read burst
    cyc(1, 0, 0);
    cyc(0, 6, 1);
    cyc(0, 6, 1); cyc(0, 6, 1); cyc(0, 6, 1);
    chk("t6_pre_ptr", int'(rd_ptr), 3);
    cyc(1, 6, 0);
    chk("t6_rst_ptr", int'(rd_ptr), 0);
    chk("t6_rst_valid", int'(rd_valid), 0);
    cyc(0, 6, 0);
    chk("t6_valid", int'(rd_valid), 1);
    chk("t6_count", int'(rd_count), 6);

    // Random traffic: mostly legal writer steps, rare jumps and resets
    cyc(1, 0, 0);
    w = 0;
    for (int i = 0; i < 600; i++) begin
      bit r;
      r = ($urandom_range(0, 79) == 0);
      if ($urandom_range(0, 59) == 0) w = (w + int'($urandom_range(2, 12))) % MOD;
      else if ($urandom_range(0, 2) != 0) w = (w + 1) % MOD;
      cyc(r, w, 1'($urandom_range(0, 1)));
    end

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
